// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] R15 = 4'hF;

  // Shadow rd is stored zero-extended so the struct is independent of REG_W.
  localparam int RD_W = 8;

  typedef struct packed {
    logic            valid;
    logic            wr;
    logic            load;
    logic [RD_W-1:0] rd;
  } shadow_t;

  typedef struct packed {
    state_t  state;
    shadow_t ex;
    shadow_t mem;
    shadow_t wb;
  } debug_t;

  function automatic logic writes_rf(input shadow_t s);
    return s.valid && s.wr;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand compare and EX > MEM > WB priority for one ID-stage source register.
import pipeline_pkg::*;

module fwd_select #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic [2:0]       wr_ok,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       sel,
  output logic             ex_hit
);

  logic live;
  logic mem_hit;
  logic wb_hit;

  // R15 reads always come from the register file (PC-relative value).
  assign live    = use_src && (src != REG_W'(R15));
  assign ex_hit  = live && wr_ok[2] && (ex_rd == src);
  assign mem_hit = live && wr_ok[1] && (mem_rd == src);
  assign wb_hit  = live && wr_ok[0] && (wb_rd == src);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit)       sel = FWD_EX;
    else if (mem_hit) sel = FWD_MEM;
    else if (wb_hit)  sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use stall, branch flush
// and memory-wait freeze with a sticky timeout error.
import pipeline_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic             ID_RF_instr,
  input  logic             ID_load_instr,
  input  logic [REG_W-1:0] ID_rd,
  input  logic [REG_W-1:0] ID_rn,
  input  logic [REG_W-1:0] ID_rm,
  input  logic             ID_use_rn,
  input  logic             ID_use_rm,
  input  logic             EX_branch_taken,
  input  logic             MEM_ready,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             IDEX_nop,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output debug_t           debug
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  shadow_t          ex_q, mem_q, wb_q, id_s;
  logic [2:0]       wr_ok;
  logic             frozen;
  logic             mem_stall;
  logic             load_use;
  logic             a_ex_hit, b_ex_hit;

  assign id_s  = {ID_valid, ID_RF_instr, ID_load_instr, RD_W'(ID_rd)};
  assign wr_ok = {writes_rf(ex_q), writes_rf(mem_q), writes_rf(wb_q)};

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src    (ID_rn),
    .use_src(ID_use_rn),
    .wr_ok  (wr_ok),
    .ex_rd  (ex_q.rd[REG_W-1:0]),
    .mem_rd (mem_q.rd[REG_W-1:0]),
    .wb_rd  (wb_q.rd[REG_W-1:0]),
    .sel    (fwd_a_sel),
    .ex_hit (a_ex_hit)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src    (ID_rm),
    .use_src(ID_use_rm),
    .wr_ok  (wr_ok),
    .ex_rd  (ex_q.rd[REG_W-1:0]),
    .mem_rd (mem_q.rd[REG_W-1:0]),
    .wb_rd  (wb_q.rd[REG_W-1:0]),
    .sel    (fwd_b_sel),
    .ex_hit (b_ex_hit)
  );

  // MEM_ready is a completion strobe: a valid MEM op finishes in the cycle it is 1;
  // while it is 0 the op is outstanding and the whole pipeline must hold.
  assign mem_stall = mem_q.valid && !MEM_ready;
  assign load_use  = ID_valid && ex_q.load && (a_ex_hit || b_ex_hit);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    frozen     = 1'b0;
    PC_en      = 1'b1;
    IFID_en    = 1'b1;
    IFID_flush = 1'b0;
    IDEX_nop   = 1'b0;
    EXMEM_en   = 1'b1;
    MEMWB_en   = 1'b1;

    case (state)
      RUN: begin
        if (mem_stall) begin
          frozen    = 1'b1;
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MEM_ready) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          frozen = 1'b1;
          if (cnt == CNT_W'(MEM_TIMEOUT)) state_nxt = ERR;
          else if (cnt != '1)             cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      ERR: frozen = 1'b1;
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase

    // Freeze beats branch, branch beats load-use (the stalled instruction is squashed).
    if (frozen) begin
      PC_en    = 1'b0;
      IFID_en  = 1'b0;
      EXMEM_en = 1'b0;
      MEMWB_en = 1'b0;
    end else if (EX_branch_taken) begin
      IFID_flush = 1'b1;
      IDEX_nop   = 1'b1;
    end else if (load_use) begin
      PC_en    = 1'b0;
      IFID_en  = 1'b0;
      IDEX_nop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!frozen) begin
      ex_q  <= IDEX_nop ? shadow_t'('0) : id_s;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign mem_err = (state == ERR);
  assign debug   = {state, ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// randomized forwarding/stall/branch traffic against a small shadow model.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [3:0] rd;
  } sh_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ID_valid, ID_RF_instr, ID_load_instr;
  logic [3:0] ID_rd, ID_rn, ID_rm;
  logic       ID_use_rn, ID_use_rm;
  logic       EX_branch_taken, MEM_ready;
  logic       PC_en, IFID_en, IFID_flush, IDEX_nop, EXMEM_en, MEMWB_en;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       mem_err;
  debug_t     dbg;

  int total = 0;
  int bad   = 0;
  logic [12:0] exp_q[$];
  sh_t m_ex, m_mem, m_wb;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_valid       (ID_valid),
    .ID_RF_instr    (ID_RF_instr),
    .ID_load_instr  (ID_load_instr),
    .ID_rd          (ID_rd),
    .ID_rn          (ID_rn),
    .ID_rm          (ID_rm),
    .ID_use_rn      (ID_use_rn),
    .ID_use_rm      (ID_use_rm),
    .EX_branch_taken(EX_branch_taken),
    .MEM_ready      (MEM_ready),
    .PC_en          (PC_en),
    .IFID_en        (IFID_en),
    .IFID_flush     (IFID_flush),
    .IDEX_nop       (IDEX_nop),
    .EXMEM_en       (EXMEM_en),
    .MEMWB_en       (MEMWB_en),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .mem_err        (mem_err),
    .debug          (dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {state, PC_en, IFID_en, IFID_flush, IDEX_nop, EXMEM_en, MEMWB_en, fwd_a, fwd_b, mem_err}
  function automatic logic [12:0] ov(input state_t st, input logic pc, input logic ifid,
                                     input logic fl, input logic nop, input logic exm,
                                     input logic mwb, input logic [1:0] a, input logic [1:0] b,
                                     input logic err);
    return {st, pc, ifid, fl, nop, exm, mwb, a, b, err};
  endfunction

  function automatic logic [12:0] nrm(input logic [1:0] a, input logic [1:0] b);
    return ov(RUN, 1, 1, 0, 0, 1, 1, a, b, 0);
  endfunction

  function automatic logic [12:0] frz(input state_t st, input logic [1:0] a, input logic [1:0] b,
                                      input logic err);
    return ov(st, 0, 0, 0, 0, 0, 0, a, b, err);
  endfunction

  function automatic logic [12:0] obs();
    return {dbg.state, PC_en, IFID_en, IFID_flush, IDEX_nop, EXMEM_en, MEMWB_en,
            fwd_a_sel, fwd_b_sel, mem_err};
  endfunction

  task automatic id(input logic v, input logic rf, input logic ld, input logic [3:0] rd,
                    input logic [3:0] rn, input logic urn, input logic [3:0] rm, input logic urm);
    ID_valid      = v;
    ID_RF_instr   = rf;
    ID_load_instr = ld;
    ID_rd         = rd;
    ID_rn         = rn;
    ID_use_rn     = urn;
    ID_rm         = rm;
    ID_use_rm     = urm;
  endtask

  // Called at a negedge with inputs already driven; checks, then moves to the next negedge.
  task automatic tick(input string tag, input logic [12:0] e);
    logic [12:0] got, want;
    exp_q.push_back(e);
    #1;
    got  = obs();
    want = exp_q.pop_front();
    check_eq(tag, 32'(got), 32'(want));
    @(negedge clk);
  endtask

  function automatic logic hit(input sh_t s, input logic [3:0] src, input logic u);
    return u && (src != 4'hF) && s.v && s.wr && (s.rd == src);
  endfunction

  function automatic logic [1:0] fsel(input logic [3:0] src, input logic u);
    if (hit(m_ex, src, u))  return 2'b01;
    if (hit(m_mem, src, u)) return 2'b10;
    if (hit(m_wb, src, u))  return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [3:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    id(0, 0, 0, 0, 0, 0, 0, 0);
    EX_branch_taken = 1'b0;
    MEM_ready       = 1'b1;
    @(negedge clk);
    tick("reset_state", nrm(0, 0));
    rst_n = 1'b1;

    // Forwarding priority
    id(1, 1, 0, 1, 0, 0, 0, 0);     tick("add_r1", nrm(0, 0));
    id(1, 1, 0, 3, 1, 1, 2, 1);     tick("fwd_ex", nrm(1, 0));
    id(1, 0, 0, 0, 1, 1, 0, 0);     tick("fwd_mem", nrm(2, 0));
    id(1, 1, 0, 1, 1, 1, 0, 0);     tick("fwd_wb", nrm(3, 0));
    id(1, 0, 0, 0, 0, 0, 0, 0);     tick("filler", nrm(0, 0));
    id(1, 1, 0, 1, 0, 0, 0, 0);     tick("add_r1_again", nrm(0, 0));
    id(1, 0, 0, 0, 1, 1, 1, 1);     tick("fwd_ex_over_wb", nrm(1, 1));
    id(1, 0, 0, 0, 1, 0, 1, 1);     tick("use_bit_gate", nrm(0, 2));

    // R15 never forwarded, even from a load in EX
    id(1, 1, 1, 15, 0, 0, 0, 0);    tick("ldr_r15", nrm(0, 0));
    id(1, 0, 0, 0, 15, 1, 15, 1);   tick("r15_no_fwd", nrm(0, 0));

    // Load-use on rm
    id(1, 1, 1, 2, 0, 0, 0, 0);     tick("ldr_r2", nrm(0, 0));
    id(1, 1, 0, 4, 3, 1, 2, 1);     tick("load_use_stall", ov(RUN, 0, 0, 0, 1, 1, 1, 0, 1, 0));
    tick("after_stall_fwd_mem", nrm(0, 2));

    // Branch beats load-use
    id(1, 1, 1, 5, 0, 0, 0, 0);     tick("ldr_r5", nrm(0, 0));
    id(1, 1, 0, 6, 5, 1, 0, 0);
    EX_branch_taken = 1'b1;         tick("branch_over_lu", ov(RUN, 1, 1, 1, 1, 1, 1, 1, 0, 0));
    EX_branch_taken = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);     tick("bubble", nrm(0, 0));

    // Memory wait: load in MEM, ready low 3 cycles
    id(1, 1, 1, 6, 0, 0, 0, 0);     tick("ldr_r6", nrm(0, 0));
    id(1, 1, 0, 7, 0, 0, 0, 0);     tick("add_r7", nrm(0, 0));
    MEM_ready = 1'b0;
    id(1, 0, 0, 0, 6, 1, 7, 1);     tick("freeze_first", frz(RUN, 2, 1, 0));
    EX_branch_taken = 1'b1;         tick("freeze_br_ignored", frz(MEM_WAIT, 2, 1, 0));
    EX_branch_taken = 1'b0;         tick("freeze_third", frz(MEM_WAIT, 2, 1, 0));
    MEM_ready = 1'b1;               tick("mem_done", ov(MEM_WAIT, 1, 1, 0, 0, 1, 1, 2, 1, 0));
    tick("shadow_kept", nrm(3, 2));

    // Timeout: 16 consecutive low cycles reach ERR
    MEM_ready = 1'b0;
    id(0, 0, 0, 0, 7, 1, 7, 1);     tick("to_first", frz(RUN, 3, 3, 0));
    for (int k = 1; k <= 15; k++) tick($sformatf("to_wait_%0d", k), frz(MEM_WAIT, 3, 3, 0));
    for (int k = 0; k < 3; k++) begin
      MEM_ready = (k == 2);
      tick($sformatf("err_sticky_%0d", k), frz(ERR, 3, 3, 1));
    end

    // Asynchronous reset out of ERR
    rst_n = 1'b0;                   tick("reset_in_err", nrm(0, 0));
    rst_n = 1'b1;
    id(0, 0, 0, 0, 0, 0, 0, 0);     tick("after_reset", nrm(0, 0));

    // Random traffic, memory always ready
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    for (int i = 0; i < 150; i++) begin
      logic v, rf, ld, urn, urm, br, lu;
      logic [3:0] rd, rn, rm;
      logic [1:0] a, b;
      sh_t nxt;
      v   = ($urandom_range(0, 3) != 0);
      rf  = 1'($urandom_range(0, 1));
      ld  = rf && ($urandom_range(0, 2) == 0);
      rd  = pick_reg();
      rn  = pick_reg();
      rm  = pick_reg();
      urn = 1'($urandom_range(0, 1));
      urm = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 7) == 0);
      id(v, rf, ld, rd, rn, urn, rm, urm);
      EX_branch_taken = br;
      a   = fsel(rn, urn);
      b   = fsel(rm, urm);
      lu  = v && m_ex.ld && (hit(m_ex, rn, urn) || hit(m_ex, rm, urm));
      nxt = '{v: v, wr: rf, ld: ld, rd: rd};
      if (br) begin
        nxt = '0;
        tick($sformatf("rnd_br_%0d", i), ov(RUN, 1, 1, 1, 1, 1, 1, a, b, 0));
      end else if (lu) begin
        nxt = '0;
        tick($sformatf("rnd_lu_%0d", i), ov(RUN, 0, 0, 0, 1, 1, 1, a, b, 0));
      end else begin
        tick($sformatf("rnd_%0d", i), nrm(a, b));
      end
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It consumes the decode control bits (load, register-file write, branch), the register numbers of the instruction in ID, a branch-taken strobe from EX and a ready strobe from data memory. It keeps its own shadow pipeline of destination registers and produces:
- operand forwarding selects for the ID-stage operand muxes;
- load-use stalls;
- branch flushes;
- whole-pipeline freezes while a data-memory access is pending.

## Interface
Parameters:
- REG_W, 4, register-number width
- MEM_TIMEOUT, 15, max consecutive cycles of mem_ready=0 before error
- CNT_W, 4, width of wait counter (must hold MEM_TIMEOUT)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ID_valid  in  1  ID holds a real instruction
- ID_RF_instr  in  1  ID instruction writes the register file
- ID_load_instr  in  1  ID instruction is a load
- ID_rd  in  REG_W  destination register of ID instruction
- ID_rn, ID_rm  in  REG_W each  source registers of ID instruction
- ID_use_rn, ID_use_rm  in  1 each  source actually read
- EX_branch_taken  in  1  branch in EX resolved taken (valid only for valid EX branch)
- MEM_ready  in  1  data memory completes the MEM-stage access this cycle
- PC_en, IFID_en  out  1 each  load enables for PC and IF/ID
- IFID_flush  out  1  turn IF/ID into a bubble at next edge
- IDEX_nop  out  1  load a bubble into ID/EX at next edge
- EXMEM_en, MEMWB_en  out  1 each  load enables for later latches
- fwd_a_sel, fwd_b_sel  out  2 each  00 RF, 01 EX result, 10 MEM result, 11 WB result
- mem_err  out  1  sticky memory-timeout flag

## Operation
Shadow stages hold, per stage, {valid, wr, load, rd}:
- EX ← ID, or a bubble when IDEX_nop=1
- MEM ← EX
- WB ← MEM
- All shadow stages hold while frozen.

A stage "matches" a source when all of the following hold:
- the stage is valid and has wr=1;
- its rd equals the source register;
- the use bit for that source is 1;
- the source register is not 4'hF (R15 is never forwarded).

Forwarding:
- Per operand, priority is EX > MEM > WB; otherwise 00.
- rn drives fwd_a_sel; rm drives fwd_b_sel.

Load-use:
- Condition: ID_valid and an EX match where EX.load=1.
- Response: PC_en=0, IFID_en=0, IDEX_nop=1 for exactly one cycle.
- The next cycle the load sits in MEM and forwards with select 10.

Branch:
- On EX_branch_taken=1: IFID_flush=1 and IDEX_nop=1; PC_en=1 to load the target.
- Branch overrides load-use (the ID instruction is squashed anyway).

FSM states RUN, MEM_WAIT, ERR:
- RUN → MEM_WAIT when MEM.valid, MEM.load or a store is in progress (any valid MEM op), and MEM_ready=0.
- MEM_WAIT: freeze everything, i.e. PC_en=IFID_en=EXMEM_en=MEMWB_en=0, IDEX_nop=0, IFID_flush=0.
  - The wait counter increments each cycle.
  - MEM_ready=1 → RUN, counter cleared.
  - Counter reaching MEM_TIMEOUT with MEM_ready=0 → ERR.
- ERR: pipeline frozen, mem_err=1. Exit only by reset.

Freeze priority: a freeze overrides branch and load-use. EX_branch_taken is ignored while frozen; the EX stage must re-present it after unfreeze.

Reset (asynchronous): all shadow valid bits 0, state RUN, counter 0, mem_err=0. Outputs during and after reset:
- PC_en=IFID_en=EXMEM_en=MEMWB_en=1
- IFID_flush=IDEX_nop=0
- fwd selects 00

Reset mid-wait or in ERR returns to RUN immediately.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and shadow state (same cycle).
- FSM and shadow registers update on the rising edge of clk.
- The cycle MEM_ready first goes 0 is itself a frozen cycle: the freeze is combinational in RUN from the MEM condition.
- Load-use costs one cycle; a taken branch costs two squashed slots.
- mem_err asserts in the cycle after the counter reaches MEM_TIMEOUT.
- Counter width arithmetic is unsigned; saturating, no wrap.

## Structure
- Shared package pipeline_pkg: state encoding (RUN, MEM_WAIT, ERR), fwd-select constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), R15 constant, and the shadow-stage struct {valid, wr, load, rd}.
- One sub-module, fwd_select: operand-compare/priority logic, instantiated twice (rn, rm).

## Test plan
- ADD R1 in EX, SUB reading R1 in ID → fwd_a_sel=01, no stall. Same with R1 in MEM → 10; in WB → 11. R1 in both EX and WB → 01.
- LDR R2 in EX, ID reads R2 as rm → one cycle PC_en=0, IFID_en=0, IDEX_nop=1; next cycle fwd_b_sel=10, no stall.
- EX_branch_taken=1 with load-use also present → IFID_flush=1, IDEX_nop=1, PC_en=1.
- Load in MEM, MEM_ready low 3 cycles → all enables 0 for 3 cycles; RUN on 4th; shadow contents unchanged.
- MEM_ready held low 16+ cycles → mem_err=1 and frozen; rst_n pulse → mem_err=0, state RUN, fwd selects 00.
- ID reads R15 with R15 write in EX → fwd_a_sel=00, no stall.
